counter_bank: RTL and testbench

Parametrised bank of N_CH independent WIDTH-bit counters driven by one shared programmable prescaler on `sys_clk`. It is the general form of the board counter logic: each channel supports host up/down/clear pulses, autocount in either direction, wrap or saturate mode, a compare match, and an overflow event. It sits between okWireIn/okTriggerIn endpoints (controls) and okWireOut/okTriggerOut endpoints (counts and events). All logic runs in the `sys_clk` domain.

---
 rtl/counter_bank_pkg.sv | 25 ++
 rtl/counter_bank_if.sv | 53 +++++
 rtl/counter_bank_ch.sv | 130 +++++++++++++
 rtl/counter_bank.sv | 75 +++++++
 tb/tb_counter_bank.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/counter_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_bank_pkg
// Description : Shared definitions for the counter bank: the per-channel step
//               encoding and a width-generic all-ones helper.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_bank_pkg;

    // Step chosen for a channel on a given cycle.
    localparam logic [1:0] STEP_HOLD = 2'd0;
    localparam logic [1:0] STEP_INC  = 2'd1;
    localparam logic [1:0] STEP_DEC  = 2'd2;
    localparam logic [1:0] STEP_CLR  = 2'd3;

    // All-ones value of a w-bit counter, returned in a 32-bit container.
    // The 33-bit intermediate keeps w == 32 from overflowing the shift.
    function automatic logic [31:0] max_value(input int w);
        logic [32:0] v;
        v = (33'd1 << w) - 33'd1;
        return v[31:0];
    endfunction

endpackage : counter_bank_pkg
`default_nettype wire

// File: rtl/counter_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_bank_if
// Description : Control/status bundle of the counter bank.
//               master : host side, drives controls, reads counts/events
//               slave  : counter bank side
//   div_reload  prescaler reload (tick period = div_reload+1 cycles)
//   ch_auto     per-channel autocount enable (level)
//   ch_dir      per-channel autocount direction, 0 up / 1 down (level)
//   ch_sat      per-channel saturate (1) or wrap (0) (level)
//   ch_clear    per-channel clear pulse
//   ch_up       per-channel increment pulse
//   ch_down     per-channel decrement pulse
//   cmp_value   per-channel compare value, channel i at [i*WIDTH +: WIDTH]
//   count       per-channel counter values, same packing
//   tick        registered prescaler tick
//   eq_zero     per-channel registered count==0
//   cmp_hit     per-channel compare-match pulse
//   ovf         per-channel wrap / blocked-step pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_bank_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) ();
    logic [DIV_W-1:0]       div_reload;
    logic [N_CH-1:0]        ch_auto;
    logic [N_CH-1:0]        ch_dir;
    logic [N_CH-1:0]        ch_sat;
    logic [N_CH-1:0]        ch_clear;
    logic [N_CH-1:0]        ch_up;
    logic [N_CH-1:0]        ch_down;
    logic [N_CH*WIDTH-1:0]  cmp_value;
    logic [N_CH*WIDTH-1:0]  count;
    logic                   tick;
    logic [N_CH-1:0]        eq_zero;
    logic [N_CH-1:0]        cmp_hit;
    logic [N_CH-1:0]        ovf;

    modport master (
        output div_reload, ch_auto, ch_dir, ch_sat, ch_clear, ch_up, ch_down,
               cmp_value,
        input  count, tick, eq_zero, cmp_hit, ovf
    );

    modport slave (
        input  div_reload, ch_auto, ch_dir, ch_sat, ch_clear, ch_up, ch_down,
               cmp_value,
        output count, tick, eq_zero, cmp_hit, ovf
    );
endinterface : counter_bank_if
`default_nettype wire

// File: rtl/counter_bank_ch.sv
`default_nettype none
// ============================================================================
// Module      : counter_bank_ch
// Description : One counter channel: step selection, wrap/saturate handling,
//               eq_zero flag, compare-match pulse and overflow pulse.
//   sys_clk    clock
//   reset      asynchronous active-high reset
//   tick       registered prescaler tick from the top level
//   auto_en    autocount enable
//   dir        autocount direction, 0 up / 1 down
//   sat        1 saturate at 0/max, 0 wrap
//   clear      clear pulse
//   up, down   increment / decrement pulses
//   cmp_value  compare value
//   count      counter value
//   eq_zero    registered count==0
//   cmp_hit    pulse when count becomes equal to cmp_value
//   ovf        pulse on wrap or on a step blocked by saturation
// Revision    : 1.0 - initial release
// ============================================================================
module counter_bank_ch
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic             sys_clk,
    input  wire logic             reset,
    input  wire logic             tick,
    input  wire logic             auto_en,
    input  wire logic             dir,
    input  wire logic             sat,
    input  wire logic             clear,
    input  wire logic             up,
    input  wire logic             down,
    input  wire logic [WIDTH-1:0] cmp_value,
    output logic      [WIDTH-1:0] count,
    output logic                  eq_zero,
    output logic                  cmp_hit,
    output logic                  ovf
);

    localparam logic [31:0]      C_MAX_FULL = max_value(WIDTH);
    localparam logic [WIDTH-1:0] C_MAX      = C_MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       w_step;
    logic [WIDTH-1:0] w_next;
    logic             w_ovf;
    logic             w_match;

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_eq_zero;
    logic             r_eq_q;
    logic             r_cmp_hit;

    // Host pulses outrank autocount; up and down together cancel out.
    always_comb begin
        w_step = STEP_HOLD;
        if (clear) begin
            w_step = STEP_CLR;
        end else if (up && down) begin
            w_step = STEP_HOLD;
        end else if (up) begin
            w_step = STEP_INC;
        end else if (down) begin
            w_step = STEP_DEC;
        end else if (auto_en && tick) begin
            w_step = dir ? STEP_DEC : STEP_INC;
        end
    end

    // A step across a boundary always flags ovf; saturate mode additionally
    // suppresses the step so the count stays pinned.
    always_comb begin
        w_next = r_count;
        w_ovf  = 1'b0;
        case (w_step)
            STEP_CLR: begin
                w_next = '0;
            end
            STEP_INC: begin
                if (r_count == C_MAX) begin
                    w_ovf  = 1'b1;
                    w_next = sat ? r_count : '0;
                end else begin
                    w_next = r_count + C_ONE;
                end
            end
            STEP_DEC: begin
                if (r_count == '0) begin
                    w_ovf  = 1'b1;
                    w_next = sat ? r_count : C_MAX;
                end else begin
                    w_next = r_count - C_ONE;
                end
            end
            default: begin
                w_next = r_count;
            end
        endcase
    end

    assign w_match = (r_count == cmp_value);

    // r_eq_q resets high so the post-reset count (0) never reads as a new hit
    // when cmp_value is also 0.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_eq_zero <= 1'b1;
            r_eq_q    <= 1'b1;
            r_cmp_hit <= 1'b0;
        end else begin
            r_count   <= w_next;
            r_ovf     <= w_ovf;
            r_eq_zero <= (r_count == '0);
            r_eq_q    <= w_match;
            r_cmp_hit <= w_match && !r_eq_q;
        end
    end

    assign count   = r_count;
    assign ovf     = r_ovf;
    assign eq_zero = r_eq_zero;
    assign cmp_hit = r_cmp_hit;

endmodule : counter_bank_ch
`default_nettype wire

// File: rtl/counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : counter_bank
// Description : Bank of N_CH independent WIDTH-bit counters sharing one
//               programmable prescaler. Holds the prescaler and instantiates
//               one counter_bank_ch per channel.
//   sys_clk  sole clock
//   reset    asynchronous active-high reset, clears all state
//   bus      counter_bank_if slave: controls in, counts and events out
// Revision    : 1.0 - initial release
// ============================================================================
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  wire logic       sys_clk,
    input  wire logic       reset,
    counter_bank_if.slave   bus
);

    logic [DIV_W-1:0]      r_div_cnt;
    logic                  r_tick;

    logic [N_CH*WIDTH-1:0] w_count;
    logic [N_CH-1:0]       w_eq_zero;
    logic [N_CH-1:0]       w_cmp_hit;
    logic [N_CH-1:0]       w_ovf;

    // Down-counting prescaler; the reload happens on the tick cycle, so the
    // first tick lands on the first edge after reset releases.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (r_div_cnt == '0) begin
            r_div_cnt <= bus.div_reload;
            r_tick    <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt - {{(DIV_W-1){1'b0}}, 1'b1};
            r_tick    <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        counter_bank_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .sys_clk   (sys_clk),
            .reset     (reset),
            .tick      (r_tick),
            .auto_en   (bus.ch_auto[i]),
            .dir       (bus.ch_dir[i]),
            .sat       (bus.ch_sat[i]),
            .clear     (bus.ch_clear[i]),
            .up        (bus.ch_up[i]),
            .down      (bus.ch_down[i]),
            .cmp_value (bus.cmp_value[i*WIDTH +: WIDTH]),
            .count     (w_count[i*WIDTH +: WIDTH]),
            .eq_zero   (w_eq_zero[i]),
            .cmp_hit   (w_cmp_hit[i]),
            .ovf       (w_ovf[i])
        );
    end

    assign bus.count   = w_count;
    assign bus.tick    = r_tick;
    assign bus.eq_zero = w_eq_zero;
    assign bus.cmp_hit = w_cmp_hit;
    assign bus.ovf     = w_ovf;

endmodule : counter_bank
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_bank
// Description : Directed self-checking bench for counter_bank. Expected
//               values are queued when stimulus is applied and popped when
//               the corresponding DUT output is sampled (1 ns after the edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_bank;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int DIV_W = 24;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    counter_bank_if #(.N_CH(N_CH), .WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

    counter_bank #(.N_CH(N_CH), .WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: observed 0x%0h expected none", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", t, obs, e);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return {24'b0, bus.count[ch*WIDTH +: WIDTH]};
    endfunction

    task automatic pulse(input int ch, input bit up, input bit dn);
        bus.ch_up[ch]   = up;
        bus.ch_down[ch] = dn;
        cyc();
        bus.ch_up[ch]   = 1'b0;
        bus.ch_down[ch] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        bus.div_reload = 24'd3;
        bus.ch_auto    = '0;
        bus.ch_dir     = '0;
        bus.ch_sat     = '0;
        bus.ch_clear   = '0;
        bus.ch_up      = '0;
        bus.ch_down    = '0;
        bus.cmp_value  = '0;
        bus.cmp_value[3*WIDTH +: WIDTH] = 8'h05;

        // ---------------- reset state ----------------
        cyc();
        push("rst_count", 32'h0);      chk(bus.count);
        push("rst_tick", 32'h0);       chk({31'b0, bus.tick});
        push("rst_eq_zero", 32'hF);    chk({28'b0, bus.eq_zero});
        push("rst_cmp_hit", 32'h0);    chk({28'b0, bus.cmp_hit});
        push("rst_ovf", 32'h0);        chk({28'b0, bus.ovf});

        // ---------------- prescaler, reload 3 ----------------
        reset = 1'b0;
        bus.ch_auto[0] = 1'b1;
        push("first_tick", 32'h1);     cyc(); chk({31'b0, bus.tick});
        push("cnt0_before_tick", 32'h0);      chk(cnt(0));
        push("tick_low_after", 32'h0); cyc(); chk({31'b0, bus.tick});
        push("cnt0_after_tick", 32'h1);       chk(cnt(0));
        for (int i = 3; i <= 6; i++) begin
            push("tick_period4", (i == 5) ? 32'h1 : 32'h0);
            cyc();
            chk({31'b0, bus.tick});
        end
        repeat (32) cyc();
        push("cnt0_10_ticks", 32'd10); chk(cnt(0));

        // ---------------- prescaler, reload 0 ----------------
        bus.div_reload = 24'd0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            if (bus.tick) found = 1'b1;
        end
        push("reload0_tick_seen", 32'h1); chk({31'b0, found});
        push("cnt0_hold_at_10", 32'd10);  chk(cnt(0));
        for (int i = 11; i <= 13; i++) begin
            push("cnt0_every_cycle", i);
            cyc();
            chk(cnt(0));
        end
        bus.ch_auto[0] = 1'b0;

        // ---------------- wrap mode, channel 1 ----------------
        push("wrap_dn_count", 32'hFF); pulse(1, 1'b0, 1'b1); chk(cnt(1));
        push("wrap_dn_ovf", 32'h1);    chk({31'b0, bus.ovf[1]});
        push("wrap_dn_ovf_1cyc", 32'h0); cyc(); chk({31'b0, bus.ovf[1]});
        push("wrap_dn_eq_zero", 32'h0);  chk({31'b0, bus.eq_zero[1]});
        push("wrap_up_count", 32'h00); pulse(1, 1'b1, 1'b0); chk(cnt(1));
        push("wrap_up_ovf", 32'h1);    chk({31'b0, bus.ovf[1]});
        push("wrap_up_eq_lag", 32'h0); chk({31'b0, bus.eq_zero[1]});
        cyc();
        push("wrap_up_eq_zero", 32'h1);  chk({31'b0, bus.eq_zero[1]});
        push("wrap_up_ovf_1cyc", 32'h0); chk({31'b0, bus.ovf[1]});

        // ---------------- saturate mode, channel 1 ----------------
        bus.ch_sat[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("sat_lo_count", 32'h00); pulse(1, 1'b0, 1'b1); chk(cnt(1));
            push("sat_lo_ovf", 32'h1);    chk({31'b0, bus.ovf[1]});
            push("sat_lo_ovf_gap", 32'h0); cyc(); chk({31'b0, bus.ovf[1]});
        end
        bus.ch_sat[1] = 1'b0;
        push("to_max_count", 32'hFF); pulse(1, 1'b0, 1'b1); chk(cnt(1));
        bus.ch_sat[1] = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            push("sat_hi_count", 32'hFF); pulse(1, 1'b1, 1'b0); chk(cnt(1));
            push("sat_hi_ovf", 32'h1);    chk({31'b0, bus.ovf[1]});
            push("sat_hi_ovf_gap", 32'h0); cyc(); chk({31'b0, bus.ovf[1]});
        end

        // ---------------- priority, channel 2 ----------------
        bus.ch_up[2] = 1'b1;
        repeat (16) cyc();
        bus.ch_up[2] = 1'b0;
        push("prio_reach_10", 32'h10);  chk(cnt(2));
        push("prio_up_down", 32'h10);   pulse(2, 1'b1, 1'b1); chk(cnt(2));
        bus.ch_clear[2] = 1'b1;
        bus.ch_up[2]    = 1'b1;
        cyc();
        bus.ch_clear[2] = 1'b0;
        bus.ch_up[2]    = 1'b0;
        push("prio_clear_up", 32'h0);   chk(cnt(2));
        push("prio_clear_no_ovf", 32'h0); chk({31'b0, bus.ovf[2]});

        // up pulse while tick is high and autocount points down
        bus.ch_auto[0] = 1'b1;
        bus.ch_dir[0]  = 1'b1;
        push("prio_tick_high", 32'h1);  chk({31'b0, bus.tick});
        bus.ch_up[0] = 1'b1;
        cyc();
        bus.ch_up[0]   = 1'b0;
        bus.ch_auto[0] = 1'b0;
        push("prio_up_over_auto", 32'd14); chk(cnt(0));

        // ---------------- compare, channel 3 (cmp=5) ----------------
        bus.ch_up[3] = 1'b1;
        repeat (3) cyc();
        bus.ch_up[3] = 1'b0;
        push("cmp_start_3", 32'h3);     chk(cnt(3));
        pulse(3, 1'b1, 1'b0);
        push("cmp_count_5", 32'h5);     pulse(3, 1'b1, 1'b0); chk(cnt(3));
        push("cmp_hit_lag", 32'h0);     chk({31'b0, bus.cmp_hit[3]});
        push("cmp_hit_pulse", 32'h1);   cyc(); chk({31'b0, bus.cmp_hit[3]});
        for (int i = 0; i < 3; i++) begin
            push("cmp_hold_no_hit", 32'h0); cyc(); chk({31'b0, bus.cmp_hit[3]});
        end
        bus.cmp_value[3*WIDTH +: WIDTH] = 8'h07;
        cyc();
        push("cmp_moved_away", 32'h0);  cyc(); chk({31'b0, bus.cmp_hit[3]});
        bus.cmp_value[3*WIDTH +: WIDTH] = 8'h05;
        push("cmp_moved_back", 32'h1);  cyc(); chk({31'b0, bus.cmp_hit[3]});
        push("cmp_moved_single", 32'h0); cyc(); chk({31'b0, bus.cmp_hit[3]});

        // ---------------- reset mid-operation ----------------
        bus.ch_up[2] = 1'b1;
        repeat (65) cyc();
        bus.ch_up[1] = 1'b1;
        cyc();
        bus.ch_up[1] = 1'b0;
        bus.ch_up[2] = 1'b0;
        push("pre_rst_count_42", 32'h42); chk(cnt(2));
        push("pre_rst_ovf_high", 32'h1);  chk({31'b0, bus.ovf[1]});
        #2;
        reset = 1'b1;
        #1;
        push("async_rst_count", 32'h0);   chk(bus.count);
        push("async_rst_tick", 32'h0);    chk({31'b0, bus.tick});
        push("async_rst_eq_zero", 32'hF); chk({28'b0, bus.eq_zero});
        push("async_rst_cmp_hit", 32'h0); chk({28'b0, bus.cmp_hit});
        push("async_rst_ovf", 32'h0);     chk({28'b0, bus.ovf});
        cyc();
        reset = 1'b0;
        bus.div_reload = 24'd3;
        push("post_rst_first_tick", 32'h1); cyc(); chk({31'b0, bus.tick});
        push("post_rst_no_hit", 32'h0);     chk({28'b0, bus.cmp_hit});
        for (int i = 2; i <= 5; i++) begin
            push("post_rst_tick_seq", (i == 5) ? 32'h1 : 32'h0);
            cyc();
            chk({31'b0, bus.tick});
            push("post_rst_no_hit_seq", 32'h0); chk({28'b0, bus.cmp_hit});
        end
        push("post_rst_eq_zero", 32'hF);    chk({28'b0, bus.eq_zero});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_counter_bank
`default_nettype wire
